// File: rtl/pg_pkg.sv
// Shared definitions for the pattern-generator sequencing blocks.
package pg_pkg;

    localparam int PG_PAT_W  = 3;
    localparam int PG_HOLD_W = 8;
    localparam int PG_FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pg_frm_edge.sv
// Registers the timing-engine frame-start flag and flags its rising edge.
// The register resets high because the flag idles high while the engine is off.
module pg_frm_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic frm_st,
    output logic fb
);

    logic frm_st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_st_q <= 1'b1;
        end else begin
            frm_st_q <= frm_st;
        end
    end

    assign fb = frm_st & ~frm_st_q;

endmodule

// File: rtl/pg_seq_ctrl.sv
// Frame-synchronous sequencer: starts/stops the timing engine on frame
// boundaries and steps a pattern ID through a shadowed, programmable range.
module pg_seq_ctrl
    import pg_pkg::*;
#(
    parameter int PAT_W  = PG_PAT_W,
    parameter int HOLD_W = PG_HOLD_W,
    parameter int FCNT_W = PG_FCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [PAT_W-1:0]  pat_first,
    input  logic [PAT_W-1:0]  pat_last,
    input  logic [HOLD_W-1:0] hold_frames,
    input  logic [FCNT_W-1:0] run_frames,
    input  logic              pg_frm_st,
    output logic              pg_en,
    output logic [PAT_W-1:0]  pat_id,
    output logic              pat_upd,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              done
);

    pg_state_t         state, state_d;
    logic [PAT_W-1:0]  sh_first, sh_first_d, sh_last, sh_last_d;
    logic [PAT_W-1:0]  pat_id_d, pat_nxt;
    logic [HOLD_W-1:0] sh_hold, sh_hold_d, hold_cnt, hold_cnt_d, hold_inc, hold_eff;
    logic [FCNT_W-1:0] sh_run, sh_run_d, frame_cnt_d, frame_inc;
    logic              fb_raw, fb, en_q, en_d, pat_upd_d, done_d;

    pg_frm_edge u_frm_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .frm_st (pg_frm_st),
        .fb     (fb_raw)
    );

    assign fb        = fb_raw & (state != IDLE);
    assign frame_inc = frame_cnt + FCNT_W'(1);
    assign hold_inc  = hold_cnt + HOLD_W'(1);
    assign hold_eff  = (sh_hold == '0) ? HOLD_W'(1) : sh_hold;
    // An ID outside the current range (inverted range or a shrunk range) restarts at the first pattern.
    assign pat_nxt   = (pat_id >= sh_last || pat_id < sh_first) ? sh_first : pat_id + PAT_W'(1);

    assign pg_en = en_q;
    assign busy  = en_q;

    always_comb begin
        state_d     = state;
        sh_first_d  = sh_first;
        sh_last_d   = sh_last;
        sh_hold_d   = sh_hold;
        sh_run_d    = sh_run;
        pat_id_d    = pat_id;
        pat_upd_d   = 1'b0;
        frame_cnt_d = frame_cnt;
        hold_cnt_d  = hold_cnt;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RUN;
                    sh_first_d  = pat_first;
                    sh_last_d   = pat_last;
                    sh_hold_d   = hold_frames;
                    sh_run_d    = run_frames;
                    pat_id_d    = pat_first;
                    pat_upd_d   = 1'b1;
                    frame_cnt_d = '0;
                    hold_cnt_d  = '0;
                end
            end
            RUN: begin
                if (fb) begin
                    frame_cnt_d = frame_inc;
                    if (sh_run != '0 && frame_inc == sh_run) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (hold_inc >= hold_eff) begin
                            hold_cnt_d = '0;
                            pat_id_d   = pat_nxt;
                            pat_upd_d  = (pat_nxt != pat_id);
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                        // Decisions above used the old shadow; the new config governs the next frame.
                        sh_first_d = pat_first;
                        sh_last_d  = pat_last;
                        sh_hold_d  = hold_frames;
                        sh_run_d   = run_frames;
                        if (stop) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fb) begin
                    frame_cnt_d = frame_inc;
                    state_d     = IDLE;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_q      <= 1'b0;
            sh_first  <= '0;
            sh_last   <= '0;
            sh_hold   <= '0;
            sh_run    <= '0;
            pat_id    <= '0;
            pat_upd   <= 1'b0;
            frame_cnt <= '0;
            hold_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            en_q      <= en_d;
            sh_first  <= sh_first_d;
            sh_last   <= sh_last_d;
            sh_hold   <= sh_hold_d;
            sh_run    <= sh_run_d;
            pat_id    <= pat_id_d;
            pat_upd   <= pat_upd_d;
            frame_cnt <= frame_cnt_d;
            hold_cnt  <= hold_cnt_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pg_seq_ctrl.sv
// Self-checking bench for pg_seq_ctrl: a vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_pg_seq_ctrl;

    logic        clk, rst_n, start, stop, pg_frm_st;
    logic [2:0]  pat_first, pat_last, pat_id;
    logic [7:0]  hold_frames;
    logic [15:0] run_frames, frame_cnt;
    logic        pg_en, pat_upd, busy, done;

    pg_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pat_first   (pat_first),
        .pat_last    (pat_last),
        .hold_frames (hold_frames),
        .run_frames  (run_frames),
        .pg_frm_st   (pg_frm_st),
        .pg_en       (pg_en),
        .pat_id      (pat_id),
        .pat_upd     (pat_upd),
        .frame_cnt   (frame_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        frm;
        logic        en;
        logic [2:0]  pat;
        logic        upd;
        logic [15:0] fcnt;
        logic        done;
    } vec_t;

    vec_t tbl[16];
    int   total = 0;
    int   bad   = 0;
    bit   tbl_mode, model_chk;
    int   eng_cnt, flen;
    bit   en_seen;

    // Reference model state: a run is active or not, may be draining, and walks a pattern list.
    bit m_act, m_drain, m_frmq, m_upd, m_done;
    int m_pat, m_fcnt, m_hold;
    int c_first, c_last, c_hold, c_run;

    function automatic vec_t mk(int s, int p, int f, int e, int pat, int u, int fc, int d);
        vec_t v;
        v.start = 1'(s);
        v.stop  = 1'(p);
        v.frm   = 1'(f);
        v.en    = 1'(e);
        v.pat   = 3'(pat);
        v.upd   = 1'(u);
        v.fcnt  = 16'(fc);
        v.done  = 1'(d);
        return v;
    endfunction

    function automatic int next_pat(int pat, int first, int last);
        int seq[$];
        int idx;
        if (first > last) seq.push_back(first);
        else for (int p = first; p <= last; p++) seq.push_back(p);
        idx = -1;
        foreach (seq[i]) if (seq[i] == pat) idx = i;
        if (idx < 0) return seq[0];
        return seq[(idx + 1) % seq.size()];
    endfunction

    task automatic checkField(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic checkOutput(string tag, int en, int pat, int upd, int fcnt, int dn);
        checkField({tag, ".pg_en"}, int'(pg_en), en);
        checkField({tag, ".busy"}, int'(busy), en);
        checkField({tag, ".pat_id"}, int'(pat_id), pat);
        checkField({tag, ".pat_upd"}, int'(pat_upd), upd);
        checkField({tag, ".frame_cnt"}, int'(frame_cnt), fcnt);
        checkField({tag, ".done"}, int'(done), dn);
    endtask

    task automatic applyStimulus(vec_t v);
        start     = v.start;
        stop      = v.stop;
        pg_frm_st = v.frm;
    endtask

    task automatic model_reset();
        m_act = 0; m_drain = 0; m_frmq = 1; m_upd = 0; m_done = 0;
        m_pat = 0; m_fcnt = 0; m_hold = 0;
        c_first = 0; c_last = 0; c_hold = 0; c_run = 0;
    endtask

    task automatic model_step();
        bit fb;
        int np;
        fb     = pg_frm_st && !m_frmq && m_act;
        m_frmq = pg_frm_st;
        m_upd  = 0;
        m_done = 0;
        if (!m_act) begin
            if (start && !stop) begin
                m_act = 1; m_drain = 0;
                c_first = pat_first; c_last = pat_last; c_hold = hold_frames; c_run = run_frames;
                m_pat = pat_first; m_upd = 1; m_fcnt = 0; m_hold = 0;
            end
        end else if (fb) begin
            m_fcnt = (m_fcnt + 1) % 65536;
            if (m_drain || (c_run != 0 && m_fcnt == c_run)) begin
                m_act  = 0;
                m_done = 1;
            end else begin
                m_hold++;
                if (m_hold >= ((c_hold == 0) ? 1 : c_hold)) begin
                    m_hold = 0;
                    np     = next_pat(m_pat, c_first, c_last);
                    m_upd  = (np != m_pat);
                    m_pat  = np;
                end
                c_first = pat_first; c_last = pat_last; c_hold = hold_frames; c_run = run_frames;
                if (stop) m_drain = 1;
            end
        end else if (stop) begin
            m_drain = 1;
        end
    endtask

    // Timing-engine stand-in: flag idles high when disabled, pulses high once per frame.
    task automatic engine_update();
        if (!en_seen) eng_cnt = 0;
        else eng_cnt = (eng_cnt >= flen - 1) ? 0 : eng_cnt + 1;
        en_seen   = pg_en;
        pg_frm_st = !pg_en || (eng_cnt == 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (model_chk) checkOutput("model", int'(m_act), m_pat, int'(m_upd), m_fcnt, int'(m_done));
        if (!tbl_mode) engine_update();
    endtask

    task automatic set_cfg(int f, int l, int h, int r);
        pat_first   = 3'(f);
        pat_last    = 3'(l);
        hold_frames = 8'(h);
        run_frames  = 16'(r);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_fb();
        int n = 0;
        while (!(pg_frm_st && !m_frmq && m_act) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            total++; bad++;
            $display("[TB] FAIL fb_wait timeout at %0t: got no frame boundary, expected one", $time);
        end
    endtask

    task automatic fb_tick();
        wait_fb();
        tick();
    endtask

    task automatic wait_end(output int fc, output int nd);
        int n = 0;
        fc = -1;
        nd = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done) begin nd++; fc = int'(frame_cnt); end
            if (!pg_en) break;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("[TB] FAIL run_end timeout at %0t: got pg_en=%0d, expected 0", $time, pg_en);
        end
        repeat (3) begin
            tick();
            if (done) nd++;
        end
    endtask

    initial begin
        int fc, nd;
        $display("[TB] start");
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pg_frm_st = 1'b1;
        set_cfg(2, 4, 1, 0);
        flen = 4; eng_cnt = 0; en_seen = 0;
        tbl_mode = 1; model_chk = 0;
        model_reset();

        tbl[0]  = mk(1,0,1, 1,2,1,0,0);
        tbl[1]  = mk(0,0,1, 1,2,0,0,0);
        tbl[2]  = mk(0,0,0, 1,2,0,0,0);
        tbl[3]  = mk(0,0,0, 1,2,0,0,0);
        tbl[4]  = mk(0,0,1, 1,3,1,1,0);
        tbl[5]  = mk(0,0,0, 1,3,0,1,0);
        tbl[6]  = mk(0,0,0, 1,3,0,1,0);
        tbl[7]  = mk(0,0,1, 1,4,1,2,0);
        tbl[8]  = mk(0,0,1, 1,4,0,2,0);
        tbl[9]  = mk(0,0,0, 1,4,0,2,0);
        tbl[10] = mk(0,0,1, 1,2,1,3,0);
        tbl[11] = mk(0,1,0, 1,2,0,3,0);
        tbl[12] = mk(1,0,0, 1,2,0,3,0);
        tbl[13] = mk(0,0,1, 0,2,0,4,1);
        tbl[14] = mk(0,0,1, 0,2,0,4,0);
        tbl[15] = mk(1,1,1, 0,2,0,4,0);

        #12;
        checkOutput("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            tick();
            checkOutput($sformatf("tbl%0d", i), int'(tbl[i].en), int'(tbl[i].pat),
                        int'(tbl[i].upd), int'(tbl[i].fcnt), int'(tbl[i].done));
        end
        start = 1'b0; stop = 1'b0; pg_frm_st = 1'b1;
        tbl_mode = 0; model_chk = 1; en_seen = pg_en; eng_cnt = 0;
        tick();

        // Budget of 5 frames, two frames per pattern.
        set_cfg(0, 7, 2, 5);
        pulse_start();
        wait_end(fc, nd);
        checkField("budget.done_count", nd, 1);
        checkField("budget.frame_cnt", fc, 5);
        checkField("budget.pat_id", int'(pat_id), 2);

        // Stop in the middle of frame 3.
        set_cfg(1, 3, 1, 0);
        pulse_start();
        fb_tick(); fb_tick();
        tick();
        pulse_stop();
        wait_end(fc, nd);
        checkField("midstop.frame_cnt", fc, 3);
        checkField("midstop.done_count", nd, 1);

        // Stop coinciding with the first boundary.
        pulse_start();
        wait_fb();
        pulse_stop();
        wait_end(fc, nd);
        checkField("stopfb.frame_cnt", fc, 2);

        // Start while running is ignored.
        set_cfg(0, 3, 1, 0);
        pulse_start();
        repeat (6) tick();
        pat_first = 3'd6;
        pulse_start();
        checkField("restart.pat_upd", int'(pat_upd), 0);
        pulse_stop();
        wait_end(fc, nd);

        // Start and stop together in IDLE.
        start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0; tick();
        checkField("startstop.pg_en", int'(pg_en), 0);

        // Inverted range with hold 0.
        set_cfg(5, 1, 0, 0);
        pulse_start();
        fb_tick(); fb_tick(); fb_tick();
        checkField("pinned.pat_id", int'(pat_id), 5);
        checkField("pinned.frame_cnt", int'(frame_cnt), 3);
        pulse_stop();
        wait_end(fc, nd);

        // pat_last shrinks mid-frame: the old range governs the coming boundary.
        set_cfg(0, 7, 1, 0);
        pulse_start();
        fb_tick();
        tick();
        pat_last = 3'd1;
        fb_tick();
        checkField("relatch.pat_id_old_range", int'(pat_id), 2);
        fb_tick();
        checkField("relatch.pat_id_new_range", int'(pat_id), 0);
        pulse_stop();
        wait_end(fc, nd);

        // Asynchronous reset in the middle of a run.
        set_cfg(3, 6, 1, 0);
        pulse_start();
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset", 0, 0, 0, 0, 0);
        model_reset();
        pg_frm_st = 1'b1; en_seen = 0; eng_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        repeat (20) tick();
        pulse_stop();
        wait_end(fc, nd);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 14) == 0)
                set_cfg($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 3), $urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) flen = $urandom_range(3, 6);
            tick();
        end
        start = 1'b0; stop = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
